// File: rtl/nibble_serial_tx_pkg.sv
// Shared framing definitions for the nibble serial link (transmit and receive sides).
package nibble_serial_tx_pkg;

    localparam int unsigned DEFAULT_DATA_W       = 4;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 4;

    localparam logic TX_IDLE  = 1'b1;
    localparam logic TX_START = 1'b0;
    localparam logic TX_STOP  = 1'b1;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/nibble_serial_tx_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps, flagging the last cycle of a period.
module nibble_serial_tx_bit_timer
    import nibble_serial_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic last_cycle
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CntW-1:0] count_q, count_d;

    assign last_cycle = (count_q == CntW'(CLKS_PER_BIT - 1));

    always_comb begin
        count_d = count_q + CntW'(1);
        if (restart || last_cycle) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/nibble_serial_tx.sv
// Serial transmitter: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
module nibble_serial_tx
    import nibble_serial_tx_pkg::*;
#(
    parameter int unsigned DATA_W       = DEFAULT_DATA_W,
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter bit          PARITY_EN    = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              parity_q, parity_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              last_cycle;
    logic              accept;

    nibble_serial_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .reset     (reset),
        .restart   (state_q == StIdle),
        .last_cycle(last_cycle)
    );

    assign in_ready = (state_q == StIdle) || ((state_q == StStop) && last_cycle);
    assign accept   = in_valid && in_ready;

    // tx is registered from the next-state decision so it changes on the same edge as state.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d  = StStart;
                    shift_d  = in_data;
                    parity_d = ^in_data;
                    tx_d     = TX_START;
                end
            end
            StStart: begin
                if (last_cycle) begin
                    state_d = StData;
                    idx_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (last_cycle) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IdxW'(DATA_W - 1)) begin
                        if (PARITY_EN) begin
                            state_d = StParity;
                            tx_d    = parity_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = TX_STOP;
                        end
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                        tx_d  = shift_d[0];
                    end
                end
            end
            StParity: begin
                if (last_cycle) begin
                    state_d = StStop;
                    tx_d    = TX_STOP;
                end
            end
            StStop: begin
                if (last_cycle) begin
                    done_d = 1'b1;
                    if (accept) begin
                        state_d  = StStart;
                        shift_d  = in_data;
                        parity_d = ^in_data;
                        tx_d     = TX_START;
                    end else begin
                        state_d = StIdle;
                        tx_d    = TX_IDLE;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = TX_IDLE;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            idx_q    <= '0;
            parity_q <= 1'b0;
            tx_q     <= TX_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
